ex_muldiv_seq: RTL and testbench
================================

// Module: ex_muldiv_seq
// PURPOSE
//  Multi-cycle M-extension sequencer beside the execute stage: accepts one MUL*/DIV*/REM* op,
//  runs radix-2 shift-add multiply or restoring divide, one bit per cycle, and stalls EX until
//  the result is ready. Replaces single-cycle '*', '/', '%' in the EX ALU; EX forwards the result to MEM.
// PARAMETERS
//  XLEN    64  operand/result width
//  WLEN    32  width of *W ops
//  RDW     6   destination register tag width
// PORTS
//  clk           in   1     clock
//  reset         in   1     asynchronous, active-low reset
//  start_valid   in   1     EX presents an M-op this cycle
//  start_ready   out  1     sequencer can accept (IDLE and !flush)
//  op            in   4     0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU,
//                           8 MULW,9 DIVW,10 DIVUW,11 REMW,12 REMUW; 13-15 reserved
//  rd_in         in   RDW   destination tag, returned with result
//  rs1_val       in   XLEN  operand A (already forwarded by EX)
//  rs2_val       in   XLEN  operand B
//  flush         in   1     branch taken: abort in-flight op
//  ex_stall      out  1     hold EX pipeline registers
//  busy          out  1     state != IDLE
//  result_valid  out  1     one-cycle result strobe
//  result        out  XLEN  result; held until next result_valid
//  result_rd     out  RDW   tag of result
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; result=0, result_valid=0, result_rd=0, busy=0,
//   ex_stall=0, all counters/accumulators 0. Reset mid-operation discards the op; no strobe.
//  Accept: start_valid & start_ready at edge ending cycle N. Reserved op: accepted,
//   result=0 after normal 64-bit latency.
//  States: IDLE -> PREP -> CALC -> FIX -> DONE -> IDLE.
//   PREP  (N+1): take abs values per signedness; W ops use [31:0], sign/zero-extended per op;
//                load counter K = XLEN (64-bit ops) or WLEN (W ops).
//                Div-by-zero or signed overflow (MIN / -1) jumps to DONE.
//   CALC  (N+2..N+1+K): one partial product / quotient bit per cycle; counter decrements to 0.
//   FIX   (N+2+K): apply sign: quotient negated if operand signs differ; remainder takes dividend sign;
//                signed product negated if signs differ. Select low/high half. W ops: low 32 bits
//                sign-extended to 64 (incl. DIVUW/REMUW).
//   DONE  (N+3+K): result_valid=1 for exactly one cycle, result/result_rd updated; next cycle IDLE.
//  Latency: result_valid in cycle N+67 (64-bit), N+35 (W), N+2 (div special cases).
//  Special results: div by 0 -> quotient all-ones (W: sign-ext 0xFFFFFFFF), remainder = dividend;
//   overflow -> quotient = dividend, remainder = 0.
//  MULH/MULHSU/MULHU return product[127:64]; MULHSU treats rs2 as unsigned.
//  ex_stall = (start_valid & state==IDLE & !flush) | state in {PREP,CALC,FIX}; 0 in DONE,
//   so EX advances in the result cycle.
//  start_ready = (state==IDLE) & !flush; new op cannot be accepted in DONE (earliest N+4+K).
//  flush=1 in any state -> IDLE next edge; result_valid suppressed; result/result_rd unchanged.
//   flush and start_valid in the same cycle: flush wins, op not accepted.
//  Operands are captured at accept; later rs1_val/rs2_val/op/rd_in changes are ignored.
// TESTING
//  DIV 100,7 rd=5, accept N -> N+67 result_valid, result=14, result_rd=5; ex_stall low at N+67.
//  REM -100,7 -> -2; REMU 0xFFFFFFFFFFFFFF9C,7 -> 0xFFFFFFFFFFFFFF9C % 7 (unsigned).
//  DIVU x,0 -> all-ones at N+2; DIV 0x8000000000000000,-1 -> 0x8000000000000000;
//   REM same operands -> 0.
//  MULHU all-ones,all-ones -> 0xFFFFFFFFFFFFFFFE; MULH -1,-1 -> 0;
//   MULW 0x7FFFFFFF,2 -> 0xFFFFFFFFFFFFFFFE at N+35.
//  flush at N+20 during CALC -> IDLE at N+21, no strobe, start_ready=1; next DIV completes correctly.
//  reset low at N+10 -> all outputs 0 immediately; back-to-back ops: second accept earliest N+68.

Source files
------------

// File: rtl/ex_muldiv_seq.sv
// Sequential M-extension unit beside EX: radix-2 shift-add multiply and restoring
// divide, one bit per cycle, holding EX stalled until the result strobe.
`timescale 1ns/1ps
module ex_muldiv_seq #(
    parameter int XLEN = 64,
    parameter int WLEN = 32,
    parameter int RDW  = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [3:0]      op,
    input  logic [RDW-1:0]  rd_in,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic            flush,
    output logic            ex_stall,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result,
    output logic [RDW-1:0]  result_rd
);

    localparam int CW = $clog2(XLEN + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_CALC = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]      state;
    logic [3:0]      op_q;
    logic [RDW-1:0]  rd_q;
    logic [XLEN-1:0] a_q, b_q;
    logic [XLEN-1:0] hi, lo, m;
    logic [CW-1:0]   cnt;
    logic            neg_q, neg_r;

    function automatic logic [XLEN-1:0] sext_w(input logic [WLEN-1:0] v);
        return {{(XLEN-WLEN){v[WLEN-1]}}, v};
    endfunction

    function automatic logic [XLEN-1:0] zext_w(input logic [WLEN-1:0] v);
        return {{(XLEN-WLEN){1'b0}}, v};
    endfunction

    logic is_w, is_div, is_rem, sgn_a, sgn_b, rsv;

    always_comb begin
        is_w   = 1'b0;
        is_div = 1'b0;
        is_rem = 1'b0;
        sgn_a  = 1'b0;
        sgn_b  = 1'b0;
        rsv    = 1'b0;
        case (op_q)
            4'd0, 4'd3: rsv = 1'b0;
            4'd1:  begin sgn_a = 1'b1; sgn_b = 1'b1; end
            4'd2:  sgn_a = 1'b1;
            4'd4:  begin is_div = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; end
            4'd5:  is_div = 1'b1;
            4'd6:  begin is_div = 1'b1; is_rem = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; end
            4'd7:  begin is_div = 1'b1; is_rem = 1'b1; end
            4'd8:  is_w = 1'b1;
            4'd9:  begin is_w = 1'b1; is_div = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; end
            4'd10: begin is_w = 1'b1; is_div = 1'b1; end
            4'd11: begin is_w = 1'b1; is_div = 1'b1; is_rem = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; end
            4'd12: begin is_w = 1'b1; is_div = 1'b1; is_rem = 1'b1; end
            default: rsv = 1'b1;
        endcase
    end

    // Operand conditioning: extend W operands, then split into sign + magnitude.
    logic [XLEN-1:0] ax, bx, ma, mb, a_res, min_v, special;
    logic            a_neg, b_neg, div_zero, ovf;

    always_comb begin
        ax       = is_w ? (sgn_a ? sext_w(a_q[WLEN-1:0]) : zext_w(a_q[WLEN-1:0])) : a_q;
        bx       = is_w ? (sgn_b ? sext_w(b_q[WLEN-1:0]) : zext_w(b_q[WLEN-1:0])) : b_q;
        a_neg    = sgn_a & ax[XLEN-1];
        b_neg    = sgn_b & bx[XLEN-1];
        ma       = a_neg ? -ax : ax;
        mb       = b_neg ? -bx : bx;
        a_res    = is_w ? sext_w(a_q[WLEN-1:0]) : a_q;
        min_v    = is_w ? sext_w({1'b1, {(WLEN-1){1'b0}}}) : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = is_div & (bx == '0);
        ovf      = is_div & sgn_a & (ax == min_v) & (bx == '1);
        special  = div_zero ? (is_rem ? a_res : '1) : (is_rem ? '0 : a_res);
    end

    logic [XLEN:0]   mul_sum, div_rs;
    logic [XLEN-1:0] div_diff;
    logic            div_ge;

    always_comb begin
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
        div_rs   = {hi, lo[XLEN-1]};
        div_ge   = div_rs >= {1'b0, m};
        div_diff = div_rs[XLEN-1:0] - m;
    end

    // Sign fix-up and half selection; W products land in lo's upper WLEN bits.
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo, rem, dv, fix_val;

    always_comb begin
        prod    = {hi, lo};
        prod_s  = neg_q ? -prod : prod;
        quo     = neg_q ? -lo : lo;
        rem     = neg_r ? -hi : hi;
        dv      = is_rem ? rem : quo;
        fix_val = '0;
        if (rsv)
            fix_val = '0;
        else if (is_div)
            fix_val = is_w ? sext_w(dv[WLEN-1:0]) : dv;
        else if (is_w)
            fix_val = sext_w(lo[XLEN-1 -: WLEN]);
        else if (op_q == 4'd0)
            fix_val = prod_s[XLEN-1:0];
        else
            fix_val = prod_s[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            op_q      <= '0;
            rd_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            hi        <= '0;
            lo        <= '0;
            m         <= '0;
            cnt       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            result    <= '0;
            result_rd <= '0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_valid) begin
                        op_q  <= op;
                        rd_q  <= rd_in;
                        a_q   <= rs1_val;
                        b_q   <= rs2_val;
                        state <= S_PREP;
                    end
                end
                S_PREP: begin
                    if (div_zero | ovf) begin
                        result    <= special;
                        result_rd <= rd_q;
                        state     <= S_DONE;
                    end else begin
                        m     <= is_div ? mb : ma;
                        hi    <= '0;
                        // W divides pre-shift the dividend so its bits enter the remainder first.
                        lo    <= is_div ? (is_w ? {ma[WLEN-1:0], {(XLEN-WLEN){1'b0}}} : ma) : mb;
                        cnt   <= is_w ? CW'(WLEN) : CW'(XLEN);
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (is_div) begin
                        hi <= div_ge ? div_diff : div_rs[XLEN-1:0];
                        lo <= {lo[XLEN-2:0], div_ge};
                    end else begin
                        hi <= mul_sum[XLEN:1];
                        lo <= {mul_sum[0], lo[XLEN-1:1]};
                    end
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= S_FIX;
                end
                S_FIX: begin
                    result    <= fix_val;
                    result_rd <= rd_q;
                    state     <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy         = (state != S_IDLE);
    assign start_ready  = (state == S_IDLE) & !flush;
    assign result_valid = (state == S_DONE) & !flush;
    assign ex_stall     = (start_valid & (state == S_IDLE) & !flush) |
                          (state == S_PREP) | (state == S_CALC) | (state == S_FIX);

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Randomized bench for ex_muldiv_seq against an arithmetic reference of the M-extension ops.
`timescale 1ns/1ps
module tb_ex_muldiv_seq;

    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
    localparam logic [63:0] MINW  = 64'hFFFF_FFFF_8000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [3:0]  op = '0;
    logic [5:0]  rd_in = '0;
    logic [63:0] rs1_val = '0;
    logic [63:0] rs2_val = '0;
    logic        flush = 1'b0;
    logic        ex_stall, busy, result_valid;
    logic [63:0] result;
    logic [5:0]  result_rd;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [63:0] last_res = '0;
    logic [5:0]  last_rd = '0;

    ex_muldiv_seq dut (
        .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
        .op(op), .rd_in(rd_in), .rs1_val(rs1_val), .rs2_val(rs2_val), .flush(flush),
        .ex_stall(ex_stall), .busy(busy), .result_valid(result_valid),
        .result(result), .result_rd(result_rd)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] sx(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic [63:0] ref_res(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
        logic signed [63:0] sa, sb, sq;
        logic signed [31:0] sa32, sb32, sq32;
        logic [31:0]        ua32, ub32, t32;
        logic [127:0]       ea, eb, p;
        sa = a; sb = b; sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
        case (o)
            4'd0: return a * b;
            4'd1, 4'd2, 4'd3: begin
                ea = (o == 4'd3) ? {64'd0, a} : {{64{a[63]}}, a};
                eb = (o == 4'd1) ? {{64{b[63]}}, b} : {64'd0, b};
                p  = ea * eb;
                return p[127:64];
            end
            4'd4: begin
                if (b == 0) return '1;
                if (a == MIN64 && b == '1) return a;
                sq = sa / sb; return sq;
            end
            4'd5: return (b == 0) ? '1 : a / b;
            4'd6: begin
                if (b == 0) return a;
                if (a == MIN64 && b == '1) return 64'd0;
                sq = sa % sb; return sq;
            end
            4'd7: return (b == 0) ? a : a % b;
            4'd8: begin t32 = ua32 * ub32; return sx(t32); end
            4'd9: begin
                if (ub32 == 0) return '1;
                if (ua32 == 32'h8000_0000 && ub32 == '1) return sx(ua32);
                sq32 = sa32 / sb32; return sx(sq32);
            end
            4'd10: begin
                if (ub32 == 0) return '1;
                t32 = ua32 / ub32; return sx(t32);
            end
            4'd11: begin
                if (ub32 == 0) return sx(ua32);
                if (ua32 == 32'h8000_0000 && ub32 == '1) return 64'd0;
                sq32 = sa32 % sb32; return sx(sq32);
            end
            4'd12: begin
                if (ub32 == 0) return sx(ua32);
                t32 = ua32 % ub32; return sx(t32);
            end
            default: return 64'd0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
        bit w, d, sd, zero, ov;
        w  = (o >= 4'd8 && o <= 4'd12);
        d  = (o >= 4'd4 && o <= 4'd7) || (o >= 4'd9 && o <= 4'd12);
        sd = (o == 4'd4 || o == 4'd6 || o == 4'd9 || o == 4'd11);
        zero = w ? (b[31:0] == 0) : (b == 0);
        ov   = sd && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == '1) : (a == MIN64 && b == '1));
        if (d && (zero || ov)) return 2;
        return w ? 35 : 67;
    endfunction

    task automatic drive(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b, input logic [5:0] r);
        start_valid = 1'b1; op = o; rs1_val = a; rs2_val = b; rd_in = r;
    endtask

    task automatic scramble();
        start_valid = 1'b0;
        op      = 4'($urandom);
        rs1_val = {$urandom, $urandom};
        rs2_val = {$urandom, $urandom};
        rd_in   = 6'($urandom);
    endtask

    // Called just after the accepting edge; returns at the falling edge of the strobe cycle.
    task automatic wait_result(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b, input logic [5:0] r);
        logic [63:0] exp;
        int          lat, k;
        exp = ref_res(o, a, b);
        lat = ref_lat(o, a, b);
        k   = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (i == 1) chk("busy_stall", {62'd0, busy, ex_stall}, 64'd3);
            if (result_valid) begin k = i; break; end
        end
        chk("latency", 64'(k), 64'(lat));
        if (k != 0) begin
            chk("result", result, exp);
            chk("result_rd", {58'd0, result_rd}, {58'd0, r});
            chk("stall_in_done", {63'd0, ex_stall}, 64'd0);
        end
        last_res = exp;
        last_rd  = r;
    endtask

    task automatic run_op(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b, input logic [5:0] r);
        @(posedge clk); #1;
        drive(o, a, b, r);
        @(negedge clk);
        chk("ready", {63'd0, start_ready}, 64'd1);
        chk("stall_req", {63'd0, ex_stall}, 64'd1);
        @(posedge clk); #1;
        scramble();
        wait_result(o, a, b, r);
    endtask

    initial begin
        logic [3:0]  o;
        logic [63:0] a, b;
        int          seen;

        repeat (3) @(negedge clk);
        chk("rst_result", result, 64'd0);
        chk("rst_valid", {63'd0, result_valid}, 64'd0);
        chk("rst_rd", {58'd0, result_rd}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_stall", {63'd0, ex_stall}, 64'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_ready", {63'd0, start_ready}, 64'd1);

        // Directed corner cases
        run_op(4'd4, 64'd100, 64'd7, 6'd5);
        run_op(4'd6, -64'sd100, 64'd7, 6'd1);
        run_op(4'd7, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 6'd2);
        run_op(4'd5, 64'h1234_5678_9ABC_DEF0, 64'd0, 6'd3);
        run_op(4'd4, MIN64, '1, 6'd4);
        run_op(4'd6, MIN64, '1, 6'd6);
        run_op(4'd3, '1, '1, 6'd7);
        run_op(4'd1, '1, '1, 6'd8);
        run_op(4'd8, 64'h7FFF_FFFF, 64'd2, 6'd9);
        run_op(4'd9, MINW, '1, 6'd10);
        run_op(4'd11, 64'd55, 64'hFFFF_FFFF_0000_0000, 6'd11);
        run_op(4'd2, -64'sd3, 64'hFFFF_FFFF_FFFF_FFFF, 6'd12);
        run_op(4'd14, 64'd9, 64'd9, 6'd13);

        // Back-to-back: a request held through DONE is only taken once IDLE returns
        run_op(4'd4, 64'd1000, 64'd9, 6'd20);
        drive(4'd5, 64'd77, 64'd0, 6'd21);
        #1;
        chk("b2b_ready_done", {63'd0, start_ready}, 64'd0);
        chk("b2b_stall_done", {63'd0, ex_stall}, 64'd0);
        @(posedge clk); #1;
        chk("b2b_ready_idle", {63'd0, start_ready}, 64'd1);
        @(posedge clk); #1;
        scramble();
        wait_result(4'd5, 64'd77, 64'd0, 6'd21);

        // Flush during CALC
        @(posedge clk); #1;
        drive(4'd4, 64'd999, 64'd3, 6'd30);
        @(posedge clk); #1;
        scramble();
        repeat (19) @(negedge clk);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_no_valid", {63'd0, result_valid}, 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_idle", {63'd0, busy}, 64'd0);
        chk("flush_ready", {63'd0, start_ready}, 64'd1);
        chk("flush_hold_res", result, last_res);
        chk("flush_hold_rd", {58'd0, result_rd}, {58'd0, last_rd});
        drive(4'd5, 64'd5, 64'd1, 6'd31);
        flush = 1'b1;
        #1;
        chk("flush_wins_ready", {63'd0, start_ready}, 64'd0);
        chk("flush_wins_stall", {63'd0, ex_stall}, 64'd0);
        @(posedge clk); #1;
        scramble();
        flush = 1'b0;
        seen = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (result_valid || busy) seen++;
        end
        chk("flush_no_strobe", 64'(seen), 64'd0);
        run_op(4'd4, 64'd100, 64'd7, 6'd5);

        // Asynchronous reset mid-operation
        @(posedge clk); #1;
        drive(4'd3, '1, 64'd3, 6'd40);
        @(posedge clk); #1;
        scramble();
        repeat (10) @(negedge clk);
        chk("pre_rst_busy", {63'd0, busy}, 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_result", result, 64'd0);
        chk("mid_rst_valid", {63'd0, result_valid}, 64'd0);
        chk("mid_rst_rd", {58'd0, result_rd}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_stall", {63'd0, ex_stall}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        last_res = '0;
        last_rd  = '0;
        @(negedge clk);
        chk("post_rst_busy", {63'd0, busy}, 64'd0);
        run_op(4'd6, -64'sd100, 64'd7, 6'd41);

        // Randomized ops
        for (int n = 0; n < 50; n++) begin
            o = ($urandom_range(0, 15) == 0) ? 4'(13 + $urandom_range(0, 2)) : 4'($urandom_range(0, 12));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: b = (o >= 4'd8) ? {b[63:32], 32'd0} : 64'd0;
                1: b = 64'($urandom_range(1, 15));
                2: begin a = (o >= 4'd8) ? MINW : MIN64; b = '1; end
                3: begin a = 64'($signed(32'($urandom))); b = -64'($urandom_range(1, 100)); end
                default: ;
            endcase
            run_op(o, a, b, 6'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
